// File: rtl/map_table_pkg.sv
// Shared definitions for the rename map table: register counts, the TAG payload
// and the architectural index type.
package map_table_pkg;

  localparam int unsigned NUM_ARCH_REGS = 32;
  localparam int unsigned NUM_PHYS_REGS = 64;
  localparam int unsigned ARCH_IDX_W    = $clog2(NUM_ARCH_REGS);
  localparam int unsigned PHYS_IDX_W    = $clog2(NUM_PHYS_REGS);

  typedef struct packed {
    logic [PHYS_IDX_W-1:0] phys_reg;
    logic                  ready;
  } tag_t;

  typedef logic [ARCH_IDX_W-1:0] arch_reg_idx_t;

endpackage

// File: rtl/map_table_if.sv
// Dispatch/rename/CDB bundle between the pipeline (master) and the map table (slave).
interface map_table_if;
  import map_table_pkg::*;

  arch_reg_idx_t read_idx_1;
  arch_reg_idx_t read_idx_2;
  arch_reg_idx_t write_idx;
  tag_t          write_tag;
  logic          write_en;
  tag_t          cdb;
  tag_t          read_out_1;
  tag_t          read_out_2;
  tag_t          write_out;

  modport master (
    output read_idx_1, read_idx_2, write_idx, write_tag, write_en, cdb,
    input  read_out_1, read_out_2, write_out
  );

  modport slave (
    input  read_idx_1, read_idx_2, write_idx, write_tag, write_en, cdb,
    output read_out_1, read_out_2, write_out
  );

endinterface

// File: rtl/map_table_entry.sv
// One map-table entry: a TAG register that resets to its own index, loads a new
// mapping on rename and sets ready on a matching CDB broadcast.
module map_table_entry
  import map_table_pkg::*;
#(
  parameter int unsigned RESET_PHYS = 0
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_we,
  input  logic [PHYS_IDX_W-1:0] i_wr_phys,
  input  tag_t                  i_cdb,
  output tag_t                  o_tag
);

  tag_t r_tag;

  // Rename load beats a same-cycle broadcast, even on a matching tag.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_tag <= '{phys_reg: PHYS_IDX_W'(RESET_PHYS), ready: 1'b1};
    end else if (i_we) begin
      r_tag <= '{phys_reg: i_wr_phys, ready: 1'b0};
    end else if (i_cdb.ready && (i_cdb.phys_reg == r_tag.phys_reg)) begin
      r_tag.ready <= 1'b1;
    end
  end

  assign o_tag = r_tag;

endmodule

// File: rtl/map_table.sv
// R10K-style rename map table: 32 TAG entries, two source lookups and one rename
// per cycle. Define MAP_TABLE_CDB_BYPASS_EN to forward a live CDB ready bit to reads.
module map_table
  import map_table_pkg::*;
(
  input logic         clock,
  input logic         reset,
  map_table_if.slave  bus
);

  tag_t w_table [NUM_ARCH_REGS];
  logic w_unused_write_ready;

  // r0 is architecturally zero: fixed to {0, ready}.
  assign w_table[0]           = '{phys_reg: '0, ready: 1'b1};
  assign w_unused_write_ready = bus.write_tag.ready;

  for (genvar gi = 1; gi < NUM_ARCH_REGS; gi++) begin : g_entry
    logic w_we;
    assign w_we = bus.write_en && (bus.write_idx == ARCH_IDX_W'(gi));

    map_table_entry #(
      .RESET_PHYS (gi)
    ) u_entry (
      .i_clock   (clock),
      .i_reset   (reset),
      .i_we      (w_we),
      .i_wr_phys (bus.write_tag.phys_reg),
      .i_cdb     (bus.cdb),
      .o_tag     (w_table[gi])
    );
  end

`ifdef MAP_TABLE_CDB_BYPASS_EN
  function automatic tag_t fwd(input tag_t entry, input tag_t cdb);
    tag_t res;
    res = entry;
    if (cdb.ready && (cdb.phys_reg == entry.phys_reg)) res.ready = 1'b1;
    return res;
  endfunction

  always_comb begin
    bus.read_out_1 = fwd(w_table[bus.read_idx_1], bus.cdb);
    bus.read_out_2 = fwd(w_table[bus.read_idx_2], bus.cdb);
    bus.write_out  = fwd(w_table[bus.write_idx],  bus.cdb);
  end
`else
  always_comb begin
    bus.read_out_1 = w_table[bus.read_idx_1];
    bus.read_out_2 = w_table[bus.read_idx_2];
    bus.write_out  = w_table[bus.write_idx];
  end
`endif

endmodule

// File: tb/tb_map_table.sv
// Directed scoreboard bench for map_table; expectations follow the
// MAP_TABLE_CDB_BYPASS_EN setting of the build.
module tb_map_table;
  import map_table_pkg::*;

  typedef struct {
    string name;
    int    sel;
    tag_t  val;
  } exp_t;

  logic clock;
  logic reset;
  map_table_if bus ();

  exp_t sb[$];
  int   n_vec;
  int   n_err;

  map_table u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic tag_t mk(input int p, input logic r);
    tag_t t;
    t.phys_reg = PHYS_IDX_W'(p);
    t.ready    = r;
    return t;
  endfunction

  task automatic drive(input int r1, input int r2, input int widx, input int wphys,
                       input logic we, input int cphys, input logic crdy);
    bus.read_idx_1 = ARCH_IDX_W'(r1);
    bus.read_idx_2 = ARCH_IDX_W'(r2);
    bus.write_idx  = ARCH_IDX_W'(widx);
    bus.write_tag  = mk(wphys, 1'b1);
    bus.write_en   = we;
    bus.cdb        = mk(cphys, crdy);
  endtask

  task automatic push(input string name, input int sel, input tag_t val);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.val  = val;
    sb.push_back(e);
  endtask

  // Outputs are combinational: settle, then drain the scoreboard.
  task automatic check();
    exp_t e;
    tag_t obs;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        0:       obs = bus.read_out_1;
        1:       obs = bus.read_out_2;
        default: obs = bus.write_out;
      endcase
      n_vec++;
      assert (obs === e.val) else begin
        n_err++;
        $error("FAIL %s observed={%0d,%0b} expected={%0d,%0b}",
               e.name, obs.phys_reg, obs.ready, e.val.phys_reg, e.val.ready);
      end
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    logic bypass;
`ifdef MAP_TABLE_CDB_BYPASS_EN
    bypass = 1'b1;
`else
    bypass = 1'b0;
`endif
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    drive(0, 0, 0, 0, 1'b0, 0, 1'b0);
    next_cycle();
    reset = 1'b0;

    // Reset contents
    drive(5, 31, 7, 0, 1'b0, 0, 1'b0);
    push("rst_r1", 0, mk(5, 1'b1));
    push("rst_r2", 1, mk(31, 1'b1));
    push("rst_wo", 2, mk(7, 1'b1));
    check();

    // Rename r3 -> p40; no forward of the write to the same-cycle read
    drive(3, 0, 3, 40, 1'b1, 0, 1'b0);
    push("wr_no_fwd_r1", 0, mk(3, 1'b1));
    push("wr_old_wo", 2, mk(3, 1'b1));
    push("r0_read", 1, mk(0, 1'b1));
    check();
    next_cycle();

    drive(3, 3, 3, 0, 1'b0, 0, 1'b0);
    push("renamed_r1", 0, mk(40, 1'b0));
    check();

    // Broadcast p40: same-cycle visibility depends on bypass
    drive(3, 3, 3, 0, 1'b0, 40, 1'b1);
    push("cdb_same_r1", 0, mk(40, bypass));
    push("cdb_same_r2", 1, mk(40, bypass));
    push("cdb_same_wo", 2, mk(40, bypass));
    check();
    next_cycle();

    drive(3, 0, 0, 0, 1'b0, 0, 1'b0);
    push("cdb_next_r1", 0, mk(40, 1'b1));
    check();

    // Writes to r0 are dropped
    drive(0, 0, 0, 50, 1'b1, 0, 1'b0);
    next_cycle();
    drive(0, 3, 0, 0, 1'b0, 0, 1'b1);
    push("r0_ignored", 0, mk(0, 1'b1));
    push("r0_cdb_p0_r2", 1, mk(40, 1'b1));
    check();
    next_cycle();
    drive(0, 0, 0, 0, 1'b0, 0, 1'b0);
    push("r0_after_cdb", 0, mk(0, 1'b1));
    check();

    // Write wins over matching CDB on the renamed entry
    drive(4, 0, 4, 41, 1'b1, 41, 1'b1);
    push("wr_cdb_old_r1", 0, mk(4, 1'b1));
    check();
    next_cycle();
    drive(4, 0, 0, 0, 1'b0, 41, 1'b0);
    push("wr_beats_cdb", 0, mk(41, 1'b0));
    check();
    next_cycle();
    push("cdb_idle_keeps", 0, mk(41, 1'b0));
    check();

    // CDB updates other entries while a different entry is renamed
    drive(4, 8, 8, 43, 1'b1, 41, 1'b1);
    next_cycle();
    drive(4, 8, 7, 0, 1'b0, 0, 1'b0);
    push("cdb_other_r1", 0, mk(41, 1'b1));
    push("new_r8", 1, mk(43, 1'b0));
    push("untouched_r7", 2, mk(7, 1'b1));
    check();

    // Reset takes priority over a concurrent rename
    reset = 1'b1;
    drive(4, 8, 4, 60, 1'b1, 43, 1'b1);
    next_cycle();
    reset = 1'b0;
    drive(0, 0, 0, 0, 1'b0, 0, 1'b0);
    for (int i = 0; i < NUM_ARCH_REGS; i++) begin
      drive(i, NUM_ARCH_REGS - 1 - i, i, 0, 1'b0, 0, 1'b0);
      push("rst2_r1", 0, mk(i, 1'b1));
      push("rst2_r2", 1, mk(NUM_ARCH_REGS - 1 - i, 1'b1));
      check();
      if (i % 8 == 7) next_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
